// File: rtl/encoder_pkg.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// encoder_pkg
// Shared constants and types for the sequential 8-to-3 scan encoder.
//   N            : request vector width (fixed at 8)
//   IDXW         : index width, $clog2(N)
//   scan_state_t : controller state (IDLE while waiting for a vector,
//                  SCAN while emitting indices of the current vector)
// -----------------------------------------------------------------------------
package encoder_pkg;

   localparam int N    = 8;
   localparam int IDXW = $clog2(N);

   typedef enum logic {
      IDLE = 1'b0,
      SCAN = 1'b1
   } scan_state_t;

endpackage : encoder_pkg

// File: rtl/prio_enc8.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// prio_enc8
// Combinational LSB-first priority encoder over an 8-bit vector.
// Ports:
//   vec_i          [N-1:0]    vector to encode
//   idx_o          [IDXW-1:0] index of the lowest set bit (0 when vec_i == 0)
//   one_hot_only_o            vec_i has exactly one bit set
//   nonzero_o                 vec_i has at least one bit set
// -----------------------------------------------------------------------------
module prio_enc8
   import encoder_pkg::*;
(
   input  logic [N-1:0]    vec_i,
   output logic [IDXW-1:0] idx_o,
   output logic            one_hot_only_o,
   output logic            nonzero_o
);

   always_comb begin
      idx_o = '0;
      // Walk from MSB down so the lowest set bit is the last one written.
      for (int i = N - 1; i >= 0; i--) begin
         if (vec_i[i]) begin
            idx_o = IDXW'(i);
         end
      end
   end

   assign nonzero_o      = |vec_i;
   // Clearing the lowest set bit leaves nothing only for a one-hot vector.
   assign one_hot_only_o = nonzero_o && ((vec_i & (vec_i - N'(1))) == '0);

endmodule : prio_enc8

// File: rtl/encoder8to3_scan.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// encoder8to3_scan
// Sequential 8-to-3 encoder: accepts an 8-bit request vector and emits the
// index of every set bit, lowest first, one index per output transfer.
// Ports:
//   clk         clock, rising edge
//   rst         synchronous active-high reset
//   in_valid    D is presented
//   in_ready    block accepts D this cycle (combinational from state/out_ready)
//   D   [7:0]   request vector, any population count
//   out_valid   A holds a valid index
//   out_ready   consumer takes A this cycle
//   A   [2:0]   index of the lowest remaining set bit (0 when !out_valid)
//   last        A is the final index of the current vector
//   multi       current vector had more than one bit set when loaded
//   zero        one-cycle pulse after an all-zero vector was accepted
//   dbg_state_o current controller state, for observation only
//
// Handshake: on both ports a transfer happens on a rising edge where
// valid && ready. The source holds its data stable while valid is high and
// ready is low; valid never depends on ready. in_ready is raised in SCAN
// only on the final index being taken, so a new vector can follow the last
// index of the previous one with no bubble.
// -----------------------------------------------------------------------------
module encoder8to3_scan
   import encoder_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [N-1:0]    D,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [IDXW-1:0] A,
   output logic            last,
   output logic            multi,
   output logic            zero,
   output scan_state_t     dbg_state_o
);

   scan_state_t state_q, state_d;
   logic [N-1:0] pending_q, pending_d;
   logic         multi_q, multi_d;
   logic         zero_q, zero_d;

   logic [IDXW-1:0] enc_idx;
   logic            enc_one_hot;
   logic            enc_nonzero;

   logic in_fire;
   logic out_fire;

   prio_enc8 u_prio_enc8 (
      .vec_i          (pending_q),
      .idx_o          (enc_idx),
      .one_hot_only_o (enc_one_hot),
      .nonzero_o      (enc_nonzero)
   );

   // Outputs other than in_ready depend on registers only.
   assign out_valid   = (state_q == SCAN);
   assign A           = out_valid ? enc_idx : '0;
   assign last        = out_valid && enc_one_hot;
   assign multi       = out_valid && multi_q;
   assign zero        = zero_q;
   assign dbg_state_o = state_q;

   assign in_ready = (state_q == IDLE) || (last && out_ready);
   assign in_fire  = in_valid && in_ready;
   assign out_fire = out_valid && out_ready;

   always_comb begin
      state_d   = state_q;
      pending_d = pending_q;
      multi_d   = multi_q;
      zero_d    = 1'b0;

      // Retire the index being taken; the final one ends the vector.
      if (out_fire) begin
         pending_d = pending_q & ~(N'(1) << enc_idx);
         if (last) begin
            state_d = IDLE;
         end
      end

      // A same-cycle accept overrides the return to IDLE.
      if (in_fire) begin
         if (D != '0) begin
            pending_d = D;
            multi_d   = (D & (D - N'(1))) != '0;
            state_d   = SCAN;
         end else begin
            pending_d = '0;
            multi_d   = 1'b0;
            zero_d    = 1'b1;
            state_d   = IDLE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         pending_q <= '0;
         multi_q   <= 1'b0;
         zero_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         multi_q   <= multi_d;
         zero_q    <= zero_d;
      end
   end

endmodule : encoder8to3_scan

// File: tb/tb_encoder8to3_scan.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_encoder8to3_scan
// Directed bench for encoder8to3_scan. A queue model turns each accepted
// vector into its list of index records; one compare process checks every
// output against the model each cycle, and each directed test pins the
// transferred index sequence against hand-written literals.
// -----------------------------------------------------------------------------
module tb_encoder8to3_scan;
   import encoder_pkg::*;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic            in_valid = 1'b0;
   logic            in_ready;
   logic [N-1:0]    D = '0;
   logic            out_valid;
   logic            out_ready = 1'b1;
   logic [IDXW-1:0] A;
   logic            last;
   logic            multi;
   logic            zero;
   scan_state_t     dbg_state;

   encoder8to3_scan dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .D           (D),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .A           (A),
      .last        (last),
      .multi       (multi),
      .zero        (zero),
      .dbg_state_o (dbg_state)
   );

   // ---------------- scoreboard / model ----------------
   // Entry layout: {last, multi, idx[2:0]}
   localparam int W = 5;
   logic [W-1:0] exp_q[$];
   logic         exp_zero = 1'b0;
   logic         check_en = 1'b0;

   int checks = 0;
   int errors = 0;

   logic [IDXW-1:0] obs_q[$];   // indices actually transferred
   int              stall_cnt = 0;
   int              zero_cnt  = 0;

   function automatic logic model_ready();
      return (exp_q.size() == 0) || (exp_q[0][4] && out_ready);
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         exp_q.delete();
         exp_zero <= 1'b0;
      end else begin
         logic acc;
         acc = in_valid && model_ready();
         if ((exp_q.size() != 0) && out_ready) begin
            void'(exp_q.pop_front());
         end
         if (acc && (D != '0)) begin
            for (int i = 0; i < N; i++) begin
               if (D[i]) begin
                  exp_q.push_back({((D >> (i + 1)) == '0),
                                   ($countones(D) > 1),
                                   IDXW'(i)});
               end
            end
         end
         exp_zero <= acc && (D == '0);
      end
   end

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
      end
   endtask

   // Per-cycle compare against the model, away from the active edge.
   always @(negedge clk) begin
      if (check_en) begin
         logic ov;
         ov = (exp_q.size() != 0);
         check("out_valid", int'(out_valid), int'(ov));
         check("A",         int'(A),         ov ? int'(exp_q[0][2:0]) : 0);
         check("last",      int'(last),      ov ? int'(exp_q[0][4])   : 0);
         check("multi",     int'(multi),     ov ? int'(exp_q[0][3])   : 0);
         check("zero",      int'(zero),      int'(exp_zero));
         check("in_ready",  int'(in_ready),  int'(model_ready()));
         check("state",     int'(dbg_state), ov ? int'(SCAN) : int'(IDLE));
         if (!rst && out_valid && out_ready) obs_q.push_back(A);
         if (!rst && out_valid && !out_ready) stall_cnt++;
         if (zero) zero_cnt++;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic send(input logic [N-1:0] v);
      logic hs;
      int   budget;
      in_valid = 1'b1;
      D        = v;
      budget   = 0;
      hs       = 1'b0;
      while (!hs) begin
         @(negedge clk);
         hs = in_ready && !rst;
         @(posedge clk);
         #1;
         budget++;
         if (!hs && budget > 50) begin
            check("send_timeout", budget, 0);
            hs = 1'b1;
         end
      end
   endtask

   task automatic idle_in();
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int budget;
      budget = 0;
      while (exp_q.size() != 0 && budget < 100) begin
         @(posedge clk);
         #1;
         budget++;
      end
      if (budget >= 100) check("drain_timeout", budget, 0);
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic check_seq(input string name, input int exp_a[]);
      check({name, "_len"}, obs_q.size(), exp_a.size());
      for (int i = 0; i < exp_a.size() && i < obs_q.size(); i++) begin
         check(name, int'(obs_q[i]), exp_a[i]);
      end
      obs_q.delete();
   endtask

   // ---------------- directed tests ----------------
   initial begin
      // Reset held two cycles with a vector presented; must not be accepted.
      rst = 1'b1; in_valid = 1'b1; D = 8'hFF; out_ready = 1'b1;
      @(posedge clk); #1;
      check_en = 1'b1;
      @(posedge clk); #1;
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_A",         int'(A),         0);
      check("rst_in_ready",  int'(in_ready),  1);
      rst = 1'b0;
      send(8'hFF);
      idle_in();
      drain();
      check_seq("seq_after_reset", '{0, 1, 2, 3, 4, 5, 6, 7});

      // One-hot sweep, back-to-back.
      for (int i = 0; i < N; i++) send(N'(1) << i);
      idle_in();
      drain();
      check_seq("seq_onehot", '{0, 1, 2, 3, 4, 5, 6, 7});

      // Multi-hot vector.
      send(8'b1010_0110);
      idle_in();
      drain();
      check_seq("seq_multi", '{1, 2, 5, 7});

      // Backpressure: three stalled cycles on the first index.
      out_ready = 1'b0;
      stall_cnt = 0;
      send(8'b0001_1000);
      idle_in();
      repeat (3) @(posedge clk);
      #1;
      out_ready = 1'b1;
      drain();
      check("stall_cycles", stall_cnt, 3);
      check_seq("seq_backpressure", '{3, 4});

      // Zero vector: single zero pulse, no output.
      zero_cnt = 0;
      send(8'h00);
      idle_in();
      drain();
      check("zero_pulses", zero_cnt, 1);
      check_seq("seq_zero", '{});

      // Reset after two indices of 8'hFF have been emitted.
      send(8'hFF);
      idle_in();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("midrst_out_valid", int'(out_valid), 0);
      drain();
      check_seq("seq_midreset", '{0, 1});
      send(8'h80);
      idle_in();
      @(negedge clk);
      check("post_rst_A",     int'(A),     7);
      check("post_rst_last",  int'(last),  1);
      check("post_rst_multi", int'(multi), 0);
      drain();
      check_seq("seq_post_reset", '{7});

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

endmodule : tb_encoder8to3_scan
